// File: rtl/main_ctrl_fsm_if.sv
// Control bundle of main_ctrl_fsm: instruction fields and MemReady in, datapath strobes out.
// The master side drives the instruction fields; the FSM is the slave.
interface main_ctrl_fsm_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       Branch;
    logic       Jump;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [2:0] State;

    modport master (
        output Opcode, Funct, MemReady,
        input  IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
               MemToReg, Branch, Jump, ALUControl, Illegal, State
    );

    modport slave (
        input  Opcode, Funct, MemReady,
        output IRWrite, PCWrite, RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
               MemToReg, Branch, Jump, ALUControl, Illegal, State
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle Moore controller: beq 3, R/addi/sw 4, lw 5 cycles from FETCH; MEM stalls until MemReady.
// Optional MAIN_CTRL_JUMP_EN makes op 0x02 (j) legal, resolved in DECODE in 2 cycles.
module main_ctrl_fsm (
    input  logic           Clk,
    input  logic           Res,
    main_ctrl_fsm_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;

    logic       w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_j, w_legal;
    logic [2:0] w_alu_op;

    // Everything below decodes from the captured fields, never the live bus.
    assign w_is_lw   = (r_opcode == OP_LW);
    assign w_is_sw   = (r_opcode == OP_SW);
    assign w_is_beq  = (r_opcode == OP_BEQ);
    assign w_is_addi = (r_opcode == OP_ADDI);
    assign w_is_r    = (r_opcode == OP_RTYPE) &&
                       ((r_funct == 6'h20) || (r_funct == 6'h22) || (r_funct == 6'h24) ||
                        (r_funct == 6'h25) || (r_funct == 6'h2A));
`ifdef MAIN_CTRL_JUMP_EN
    localparam logic [5:0] OP_J = 6'h02;
    assign w_is_j    = (r_opcode == OP_J);
`else
    assign w_is_j    = 1'b0;
`endif
    assign w_legal   = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_addi | w_is_j;

    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_is_beq) begin
            w_alu_op = ALU_SUB;
        end else if (w_is_r) begin
            case (r_funct)
                6'h22:   w_alu_op = ALU_SUB;
                6'h24:   w_alu_op = ALU_AND;
                6'h25:   w_alu_op = ALU_OR;
                6'h2A:   w_alu_op = ALU_SLT;
                default: w_alu_op = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (w_legal && !w_is_j) ? S_EXEC : S_FETCH;
            S_EXEC:   w_next = w_is_beq ? S_FETCH : ((w_is_lw || w_is_sw) ? S_MEM : S_WB);
            S_MEM:    w_next = !bus.MemReady ? S_MEM : (w_is_lw ? S_WB : S_FETCH);
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            r_state  <= S_IDLE;
            r_opcode <= 6'h00;
            r_funct  <= 6'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_opcode <= bus.Opcode;
                r_funct  <= bus.Funct;
            end
        end
    end

    always_comb begin
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemToReg   = 1'b0;
        bus.Branch     = 1'b0;
        bus.Jump       = 1'b0;
        bus.ALUControl = 3'b000;
        bus.Illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.IRWrite    = 1'b1;
                bus.PCWrite    = 1'b1;
                bus.ALUControl = ALU_ADD;
            end
            S_DECODE: begin
                bus.Illegal = !w_legal;
                bus.Jump    = w_is_j;
                bus.PCWrite = w_is_j;
            end
            S_EXEC: begin
                bus.ALUSrc     = w_is_lw | w_is_sw | w_is_addi;
                bus.Branch     = w_is_beq;
                bus.ALUControl = w_alu_op;
            end
            S_MEM: begin
                bus.ALUSrc     = 1'b1;
                bus.MemRead    = w_is_lw;
                bus.MemWrite   = w_is_sw;
                bus.ALUControl = w_alu_op;
            end
            // ALUControl stays on the op so the ALU result is still valid at write-back.
            S_WB: begin
                bus.RegWrite   = 1'b1;
                bus.RegDst     = w_is_r;
                bus.MemToReg   = w_is_lw;
                bus.ALUControl = w_alu_op;
            end
            default: ;
        endcase
    end

    assign bus.State = r_state;
endmodule
